// File: rtl/cmpe200_pkg.sv
// Shared types and constants for the jump address stage.
package cmpe200_pkg;

    localparam int INDEX_W = 26;
    localparam int ADDR_W  = 32;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // One held jump transaction, with its target already formed.
    typedef struct packed {
        logic [ADDR_W-1:0] jump_addr;
        logic [ADDR_W-1:0] link_addr;
        logic              is_jal;
    } entry_t;

endpackage

// File: rtl/jump_addr_stage.sv
// Jump address stage: forms J/JAL targets and holds them in a two-entry
// in-order skid buffer.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_EMPTY | no entry held; out_valid low
//   ST_ONE   | head entry valid; a new entry may be accepted
//   ST_FULL  | head and second entry valid; in_ready low
module jump_addr_stage
    import cmpe200_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INDEX_W-1:0] instr_index,
    input  logic [ADDR_W-1:0]  pc_plus4,
    input  logic               is_jal,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  link_addr,
    output logic               link_we,
    output logic [CNT_W-1:0]   jump_cnt
);

    state_t state, state_next;
    entry_t head, tail, new_entry;
    logic   accept, deliver;
    logic   load_head, load_tail, shift_tail, cnt_inc;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    // Target is the upper PC nibble concatenated with the word-aligned index;
    // the link value is PC+4 as given (no delay slot).
    assign new_entry.jump_addr = {pc_plus4[ADDR_W-1:ADDR_W-4], instr_index, 2'b00};
    assign new_entry.link_addr = pc_plus4;
    assign new_entry.is_jal    = is_jal;

    // Next-state and entry-register load decisions; flush overrides everything.
    always_comb begin
        state_next = state;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_tail = 1'b0;
        cnt_inc    = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            cnt_inc = deliver;
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        load_head  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        load_head = 1'b1;
                    end else if (accept) begin
                        state_next = ST_FULL;
                        load_tail  = 1'b1;
                    end else if (deliver) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        state_next = ST_ONE;
                        shift_tail = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // State register; in_ready is registered so it never depends on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != ST_FULL);
        end
    end

    // Entry registers: head feeds the outputs, tail holds the second entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head) begin
                head <= new_entry;
            end else if (shift_tail) begin
                head <= tail;
            end
            if (load_tail) begin
                tail <= new_entry;
            end
        end
    end

    // Delivered-transaction counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_cnt <= '0;
        end else if (cnt_inc && (jump_cnt != {CNT_W{1'b1}})) begin
            jump_cnt <= jump_cnt + 1'b1;
        end
    end

    assign out_valid = (state != ST_EMPTY);
    assign jump_addr = head.jump_addr;
    assign link_addr = head.link_addr;
    assign link_we   = out_valid & head.is_jal;

endmodule

// File: tb/tb_jump_addr_stage.sv
// Self-checking bench for jump_addr_stage (counter narrowed to 4 bits so
// saturation is reachable quickly).
module tb_jump_addr_stage;

    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [25:0]   instr_index;
    logic [31:0]   pc_plus4;
    logic          is_jal;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   jump_addr;
    logic [31:0]   link_addr;
    logic          link_we;
    logic [CW-1:0] jump_cnt;

    jump_addr_stage #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_index(instr_index), .pc_plus4(pc_plus4), .is_jal(is_jal),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .jump_addr(jump_addr), .link_addr(link_addr), .link_we(link_we),
        .jump_cnt(jump_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] idx;
        logic [31:0] pc;
        logic        jal;
        logic [31:0] exp_jaddr;
        logic [31:0] exp_link;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic [31:0] jaddr;
        logic [31:0] link;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;
    int   n_deliv  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: inputs are stable at the falling edge, so accept/deliver
    // decided here take effect on the following rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            exp_cnt = 0;
        end
        check("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
        check("in_ready", {31'b0, in_ready}, {31'b0, sb.size() < 2});
        check("jump_cnt", {28'b0, jump_cnt}, exp_cnt);
        if (!out_valid) check("link_we_idle", {31'b0, link_we}, 32'd0);
        if (!rst && flush) begin
            sb.delete();
        end else if (!rst) begin
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_jump_addr", jump_addr, e.jaddr);
                check("sb_link_addr", link_addr, e.link);
                check("sb_link_we", {31'b0, link_we}, {31'b0, e.we});
                if (exp_cnt < CNT_MAX) exp_cnt++;
                n_deliv++;
            end
            if (in_valid && in_ready) begin
                e.jaddr = {pc_plus4[31:28], instr_index, 2'b00};
                e.link  = pc_plus4;
                e.we    = is_jal;
                sb.push_back(e);
            end
        end
    end

    task automatic drive(input logic [25:0] idx, input logic [31:0] pc, input logic jal);
        instr_index = idx;
        pc_plus4    = pc;
        is_jal      = jal;
    endtask

    vec_t vecs[5];
    logic [31:0] first_addr;
    int d0;

    initial begin
        vecs[0] = '{26'h0000100, 32'h0040_0004, 1'b0, 32'h0000_0400, 32'h0040_0004, 1'b0};
        vecs[1] = '{26'h3FF_FFFF, 32'hA000_0000, 1'b1, 32'hAFFF_FFFC, 32'hA000_0000, 1'b1};
        vecs[2] = '{26'h0000000, 32'hF000_0010, 1'b1, 32'hF000_0000, 32'hF000_0010, 1'b1};
        vecs[3] = '{26'h2AA_AAAA, 32'h5123_4568, 1'b0, 32'h5AAA_AAA8, 32'h5123_4568, 1'b0};
        vecs[4] = '{26'h155_5555, 32'h3000_0000, 1'b1, 32'h3555_5554, 32'h3000_0000, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        drive(26'h0, 32'h0, 1'b0);
        tick(); tick();
        check("rst_jump_addr", jump_addr, 32'd0);
        check("rst_link_addr", link_addr, 32'd0);
        check("rst_link_we", {31'b0, link_we}, 32'd0);
        rst = 1'b0;

        // Single-transaction vectors; first one is accepted on the first edge after reset.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            drive(vecs[i].idx, vecs[i].pc, vecs[i].jal);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            check("vec_out_valid", {31'b0, out_valid}, 32'd1);
            check("vec_jump_addr", jump_addr, vecs[i].exp_jaddr);
            check("vec_link_addr", link_addr, vecs[i].exp_link);
            check("vec_link_we", {31'b0, link_we}, {31'b0, vecs[i].exp_we});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Backpressure: three offers, two accepted, head stable, then in-order drain.
        reset_dut();
        in_valid = 1'b1;
        drive(26'h0000010, 32'h1000_0004, 1'b0); tick();
        drive(26'h0000020, 32'h2000_0004, 1'b1); tick();
        drive(26'h0000030, 32'h3000_0004, 1'b0); tick();
        in_valid = 1'b0;
        @(negedge clk);
        first_addr = 32'h1000_0040;
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_head", jump_addr, first_addr);
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_cnt", {28'b0, jump_cnt}, 32'd2);
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush while FULL with out_ready and in_valid asserted.
        in_valid = 1'b1;
        drive(26'h0000040, 32'h4000_0004, 1'b1); tick();
        drive(26'h0000050, 32'h5000_0004, 1'b0); tick();
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", {31'b0, out_valid}, 32'd0);
        check("fl_in_ready", {31'b0, in_ready}, 32'd1);
        check("fl_cnt", {28'b0, jump_cnt}, 32'd2);

        // Asynchronous reset between edges while FULL.
        in_valid = 1'b1;
        drive(26'h0000060, 32'h6000_0004, 1'b1); tick();
        drive(26'h0000070, 32'h7000_0004, 1'b1); tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", {31'b0, out_valid}, 32'd0);
        check("ar_link_we", {31'b0, link_we}, 32'd0);
        check("ar_jump_addr", jump_addr, 32'd0);
        check("ar_link_addr", link_addr, 32'd0);
        check("ar_cnt", {28'b0, jump_cnt}, 32'd0);
        tick();
        rst = 1'b0;

        // Continuous streaming: one delivery per cycle, stays in ONE, counter saturates.
        d0 = n_deliv;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 22; k++) begin
            drive(26'($urandom), $urandom, 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (k >= 1) check("st_one", {30'b0, out_valid, in_ready}, 32'd3);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("st_deliveries", n_deliv - d0, 32'd21);
        check("st_sat_cnt", {28'b0, jump_cnt}, CNT_MAX);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("st_sat_hold", {28'b0, jump_cnt}, CNT_MAX);
        check("st_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jump_addr_stage.md
JUMP_ADDR_STAGE -- requirements
Module: jump_addr_stage

Interface
REQ-001 Parameter CNT_W, default 16, width of the jump-issued counter.
REQ-002 Port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1, reset: asynchronous, active-high.
REQ-004 Port in_valid, input, 1, upstream offers a jump transaction.
REQ-005 Port in_ready, output, 1, stage can accept this cycle.
REQ-006 Port instr_index, input, 26, registered 26-bit jump index from the upstream 26-bit D flip-flop.
REQ-007 Port pc_plus4, input, 32, PC+4 of the jump instruction.
REQ-008 Port is_jal, input, 1, transaction is JAL (writes link).
REQ-009 Port flush, input, 1, discard all held transactions.
REQ-010 Port out_valid, output, 1, head entry available downstream.
REQ-011 Port out_ready, input, 1, downstream consumes the head entry.
REQ-012 Port jump_addr, output, 32, target address of the head entry.
REQ-013 Port link_addr, output, 32, link value of the head entry.
REQ-014 Port link_we, output, 1, head entry is JAL; qualified by out_valid.
REQ-015 Port jump_cnt, output, CNT_W, count of transactions delivered downstream.

Function
REQ-016 Accept = in_valid & in_ready; deliver = out_valid & out_ready.
REQ-017 jump_addr = {pc_plus4[31:28], instr_index, 2'b00}, formed at accept and stored as 32 bits.
REQ-018 link_addr = pc_plus4, unmodified; no delay-slot adjustment.
REQ-019 Two-entry in-order skid buffer; FSM states EMPTY, ONE, FULL.
REQ-020 EMPTY: accept -> ONE; otherwise stay.
REQ-021 ONE: accept & no deliver -> FULL; deliver & no accept -> EMPTY; accept & deliver -> ONE, new entry becomes head.
REQ-022 FULL: deliver -> ONE, second entry becomes head; no accept possible.
REQ-023 in_ready = (state != FULL), driven from a register only; no combinational path from out_ready.
REQ-024 out_valid = (state != EMPTY); outputs show the head entry; head is stable while out_valid & !out_ready.
REQ-025 Latency: an entry accepted at edge N is visible at the outputs after edge N (one cycle); empty-stage throughput is 1 per cycle.
REQ-026 flush has priority: next state is EMPTY, and accept and deliver in the flush cycle are ignored. jump_cnt does not increment in the flush cycle.
REQ-027 jump_cnt increments by 1 per deliver and saturates at all-ones; no wrap.
REQ-028 Output data when out_valid=0 is don't-care. link_we is 0 when out_valid=0.

Reset
REQ-029 rst asserted forces state EMPTY, in_ready 1 (after release), out_valid 0, link_we 0, jump_addr 0, link_addr 0, jump_cnt 0, independent of clk.
REQ-030 Reset mid-operation discards all held entries; the first accept is possible on the first rising edge after deassertion.

Structure
REQ-031 Package cmpe200_pkg holds the FSM state enum and the constants INDEX_W=26 and ADDR_W=32.
REQ-032 Single module; no sub-module. Address formation is inline combinational logic feeding the entry registers.

Verification
REQ-033 Reset, then accept index 26'h0000100 with pc_plus4 32'h0040_0004 -> after 1 cycle, out_valid=1, jump_addr=32'h0000_0400.
REQ-034 Accept index 26'h3FF_FFFF with pc_plus4 32'hA000_0000 and is_jal=1 -> jump_addr=32'hAFFF_FFFC, link_addr=32'hA000_0000, link_we=1.
REQ-035 Hold out_ready=0 and offer 3 back-to-back transactions -> 2 accepted, in_ready=0, head unchanged. Release out_ready -> both delivered in order, jump_cnt=2.
REQ-036 In state FULL, assert flush together with out_ready=1 -> next cycle out_valid=0, in_ready=1, jump_cnt unchanged.
REQ-037 Assert rst asynchronously between edges while FULL -> outputs clear immediately; run a preloaded count of CNT_W all-ones with further delivers -> jump_cnt stays all-ones.
REQ-038 Hold in_valid=1 and out_ready=1 continuously for 10 cycles -> 10 deliveries, one per cycle, and state remains ONE.
